imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Sits upstream of the single-cycle MIPS core.
- Receives a program image as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them into instruction memory starting at word 0.
- Holds the core in reset until the image is loaded and its checksum is verified, then releases it.
- Makes the core bootable without recompiling a memory init file.

Parameters:
ADDR_W, 10, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset; restarts the load sequence
in_data  input  8  incoming image byte
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  word to write
cpu_rst  output  1  reset to the MIPS core (its rst input); high until load succeeds
done  output  1  image loaded and verified; core running
error  output  1  load failed; core held in reset
err_code  output  2  00 none, 01 length overflow, 10 checksum mismatch
words_loaded  output  ADDR_W+1  count of words written so far

Behaviour:
- Image format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N*4 data bytes: each word big-endian, first byte is wdata[31:24].
  - One checksum byte: the XOR of all data bytes only, not the length bytes.
- Byte transfer: a byte is accepted when in_valid && in_ready are both high on a rising edge. in_data is ignored otherwise.
- in_ready:
  - = !rst && state in {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK}.
  - Combinational from the state register.
  - Low in S_RUN and S_ERROR.
- Reset, while rst is high (sync): state=S_LEN_HI; cpu_rst=1; done=0; error=0; err_code=00; imem_we=0; imem_addr=0; imem_wdata=0; words_loaded=0. The internal byte index, word counter, length register and XOR accumulator are all cleared.
- Reset mid-load: aborts the load. Words already written stay in memory; the next image overwrites them from word 0.
- State machine:
  - S_LEN_HI:
    - On accept, latch len[15:8] and go to S_LEN_LO.
  - S_LEN_LO:
    - On accept, latch len[7:0].
    - If {len_hi,in_data} > 2^ADDR_W: go to S_ERROR, err_code=01.
    - Else if it is 0: go to S_CHECK.
    - Else go to S_DATA.
  - S_DATA:
    - Shift each accepted byte into a 32-bit assembly register.
    - XOR the byte into the accumulator.
    - A 2-bit byte index wraps 3->0.
    - On acceptance of the 4th byte of a word:
      - The next cycle imem_we=1 for exactly one cycle, with imem_wdata = the assembled word and imem_addr = the current word index.
      - words_loaded increments in that same cycle.
      - Write latency is 1 cycle after the 4th byte's accept edge.
    - Back-to-back words at full rate are supported; no bubble is required.
    - After the 4th byte of word N-1 is accepted, go to S_CHECK.
  - S_CHECK:
    - On accept, compare in_data with the accumulator.
    - Equal: go to S_RUN.
    - Different: go to S_ERROR, err_code=10.
    - The final imem write (issued the cycle after the last data byte) always completes before this comparison, because the checksum byte arrives at least one cycle later.
  - S_RUN:
    - cpu_rst=0 and done=1 from the cycle after the checksum accept, held until rst.
    - in_ready=0; further bytes are ignored.
  - S_ERROR:
    - error=1, cpu_rst=1, err_code held, in_ready=0.
    - Only rst leaves this state.
- Word address:
  - Writes to word index i, 0..N-1.
  - N = 2^ADDR_W exactly is legal; the last address is all-ones. The counter is ADDR_W+1 bits wide, so there is no wrap.
- in_valid low in any state: state holds, and so do counters and accumulator.
- imem_we: never asserted outside S_DATA, except on the single cycle following the last data byte.
- cpu_rst: registered, so it is glitch-free.

Test Plan:
- Single-word load:
  - Stimulus: reset, then bytes 00 01 DE AD BE EF, checksum 0x22 (DE^AD^BE^EF), in_valid constant.
  - Required response: one imem_we pulse with addr=0, wdata=0xDEADBEEF, the cycle after the EF accept; done=1 and cpu_rst=0 the cycle after the checksum; words_loaded=1.
- Three-word load with random in_valid gaps:
  - Stimulus: words 0x20080005, 0x20090003, 0x01095020, correct checksum.
  - Required response: writes at addr 0, 1, 2 with those values in order; exactly 3 imem_we pulses; done=1.
- Checksum mismatch:
  - Stimulus: the single-word image with checksum 0x23.
  - Required response: error=1, err_code=10, cpu_rst stays 1, in_ready=0 afterwards, done=0.
- Length overflow, ADDR_W=10:
  - Stimulus: length bytes 04 01 (1025).
  - Required response: S_ERROR after LEN_LO, err_code=01, no imem_we ever asserted.
  - Boundary: length 04 00 followed by 4096 bytes and a correct checksum gives the last write at addr=0x3FF and done=1.
- Zero length:
  - Stimulus: 00 00 then checksum 00.
  - Required response: done=1, no writes.
  - Variant: checksum 01 gives err_code=10.
- Reset mid-load:
  - Stimulus: assert rst after 2 data bytes of word 1, then a full one-word image.
  - Required response: outputs at reset values the cycle after rst; the new word is written at addr=0; done=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader for the single-cycle MIPS core.
// Receives a length-prefixed, XOR-checksummed byte image over valid/ready,
// packs big-endian 32-bit words into instruction memory from word 0, and
// keeps the core in reset until the whole image has been checked.
module imem_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;          // first three bytes of the word in flight
    logic [7:0]        xor_q, xor_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              accept;
    logic [15:0]       len_new;

    // Ready only while the image is still being consumed; rst gates it so no
    // byte is considered taken during the reset cycle.
    always_comb begin
        in_ready = !rst && (state_q == S_LEN_HI || state_q == S_LEN_LO ||
                            state_q == S_DATA   || state_q == S_CHECK);
        accept   = in_valid && in_ready;
        len_new  = {len_q[15:8], in_data};
    end

    // Next-state and datapath updates; every register holds unless a byte is taken.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        xor_d        = xor_q;
        words_d      = words_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_d    = cpu_rst_q;
        done_d       = done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;

        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    if (32'(len_new) > CAPACITY) begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = 2'b01;
                    end else if (len_new == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_d      = xor_q ^ in_data;
                    asm_d      = {asm_q[15:0], in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Word complete: address is the count before this word.
                        imem_we_d    = 1'b1;
                        imem_addr_d  = words_q[ADDR_W-1:0];
                        imem_wdata_d = {asm_q, in_data};
                        words_d      = words_q + 1'b1;
                        if (32'(words_d) == 32'(len_q)) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (in_data == xor_q) begin
                        state_d   = S_RUN;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = 2'b10;
                    end
                end
            end
            S_RUN, S_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_LEN_HI;
            end
        endcase
    end

    // State and output registers; reset restarts the load and holds the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LEN_HI;
            len_q        <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            xor_q        <= '0;
            words_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            xor_q        <= xor_d;
            words_q      <= words_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: drives byte images with random valid gaps and
// checks writes, timing and final status against an image-level model.
module tb_imem_boot_loader;

    localparam int AW  = 10;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic [AW:0]   words_loaded;

    imem_boot_loader #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    logic [7:0]  img[$];
    int          acc_cyc[$];
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic [31:0] mem [CAP];

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction-memory model plus a log of every write strobe seen.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
            mem[imem_addr] = imem_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        acc_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        check("rst_words_loaded", 64'(words_loaded), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        clear_logs();
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Image with n words of random data; checksum optionally corrupted.
    task automatic build(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x ^= b;
            img.push_back(b);
        end
        img.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(254))) : x);
    endtask

    // Streams img; with check_final set, compares against the image-level model.
    task automatic run_image(input string name, input int gap_pct, input bit check_final);
        int   idx;
        int   iter;
        int   budget;
        bit   broke;
        int   n;
        bit   ovf;
        bit   good;
        logic [7:0]  chk;
        logic [31:0] w;
        int   last;
        idx    = 0;
        iter   = 0;
        broke  = 1'b0;
        budget = 8 * img.size() + 200;
        while (idx < img.size() && iter < budget) begin
            @(negedge clk);
            iter++;
            if (!in_ready) begin
                broke = 1'b1;
                break;
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = img[idx];
                acc_cyc.push_back(cyc);
                idx++;
            end
        end
        check({name, "_budget"}, 64'(iter >= budget && idx < img.size()), 64'd0);
        if (!broke) @(negedge clk);
        in_valid = 1'b0;
        if (!check_final) return;

        n   = int'({img[0], img[1]});
        ovf = (n > CAP);
        chk = 8'h00;
        if (!ovf) for (int i = 0; i < 4 * n; i++) chk ^= img[2 + i];
        good = !ovf && (img[2 + 4 * n] == chk);

        check({name, "_done"}, 64'(done), 64'(good));
        check({name, "_error"}, 64'(error), 64'(!good));
        check({name, "_cpu_rst"}, 64'(cpu_rst), 64'(!good));
        check({name, "_err_code"}, 64'(err_code), ovf ? 64'd1 : (good ? 64'd0 : 64'd2));
        check({name, "_in_ready"}, 64'(in_ready), 64'd0);
        check({name, "_words_loaded"}, 64'(words_loaded), ovf ? 64'd0 : 64'(n));
        check({name, "_num_writes"}, 64'(wr_addr.size()), ovf ? 64'd0 : 64'(n));
        if (!ovf && wr_addr.size() == n) begin
            for (int k = 0; k < n; k++) begin
                w = {img[2 + 4*k], img[3 + 4*k], img[4 + 4*k], img[5 + 4*k]};
                check({name, "_wr_addr"}, 64'(wr_addr[k]), 64'(k));
                check({name, "_wr_data"}, 64'(wr_data[k]), 64'(w));
                check({name, "_wr_time"}, 64'(wr_cyc[k]), 64'(acc_cyc[5 + 4*k] + 1));
                check({name, "_mem"}, 64'(mem[k]), 64'(w));
            end
        end
        if (ovf && wr_addr.size() == 0) begin
            last = 0;
        end else if (n > 0 && wr_addr.size() > 0) begin
            last = wr_addr[wr_addr.size() - 1];
            check({name, "_last_addr"}, 64'(last), 64'(n - 1));
        end
        // A few idle cycles with junk on the bus must change nothing.
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_hold_done"}, 64'(done), 64'(good));
        check({name, "_hold_writes"}, 64'(wr_addr.size()), ovf ? 64'd0 : 64'(n));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < CAP; i++) mem[i] = 32'h0;

        // Single word, continuous valid.
        do_reset();
        img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        run_image("one_word", 0, 1'b1);

        // Three words with random gaps.
        do_reset();
        img = '{8'h00, 8'h03,
                8'h20, 8'h08, 8'h00, 8'h05,
                8'h20, 8'h09, 8'h00, 8'h03,
                8'h01, 8'h09, 8'h50, 8'h20,
                8'h00};
        for (int i = 2; i < 14; i++) img[14] ^= img[i];
        run_image("three_word", 35, 1'b1);

        // Checksum mismatch.
        do_reset();
        img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
        run_image("bad_chk", 0, 1'b1);

        // Length overflow (1025 words).
        do_reset();
        img = '{8'h04, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        run_image("overflow", 20, 1'b1);

        // Exact capacity: 1024 words.
        do_reset();
        build(CAP, 1'b0);
        run_image("full_cap", 0, 1'b1);

        // Zero length, good and bad checksum.
        do_reset();
        img = '{8'h00, 8'h00, 8'h00};
        run_image("zero_len", 10, 1'b1);
        do_reset();
        img = '{8'h00, 8'h00, 8'h01};
        run_image("zero_len_bad", 0, 1'b1);

        // Reset two bytes into word 1, then a fresh one-word image.
        do_reset();
        img = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h55, 8'h66};
        run_image("partial", 0, 1'b0);
        do_reset();
        img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        run_image("after_abort", 0, 1'b1);

        // Random images of assorted lengths and checksum validity.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            build(int'($urandom_range(9)), ($urandom_range(2) == 0));
            run_image("random", int'($urandom_range(50)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
